// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 (CPOL=0, CPHA=0) master transaction controller.
// Streams 1..16 MSB-first bytes inside one chip-select window; SCK half-period is DIV clocks.
module spi_xfer_ctrl #(
  parameter int unsigned DIV = 2
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic       start_i,
  input  logic [3:0] len_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       sck_o,
  output logic       csn_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_e;

  localparam logic [7:0] DIV_RELOAD = 8'(DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic [3:0] edge_cnt_q, edge_cnt_d;
  logic [3:0] rem_q, rem_d;
  logic       first_q, first_d;
  logic       sck_q, sck_d;
  logic       csn_q, csn_d;
  logic       mosi_q, mosi_d;
  logic       tx_ready_q, tx_ready_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       div_tick;

  assign div_tick = (div_cnt_q == 8'd0);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    rem_d      = rem_q;
    first_d    = first_q;
    sck_d      = sck_q;
    csn_d      = csn_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          rem_d     = len_i;
          first_d   = 1'b1;
          div_cnt_d = DIV_RELOAD;
          state_d   = LOAD;
        end
      end

      LOAD: begin
        sck_d = 1'b0;
        if (tx_valid_i && tx_ready_q) begin
          tx_sh_d    = tx_data_i;
          mosi_d     = tx_data_i[7];
          edge_cnt_d = 4'd0;
          div_cnt_d  = DIV_RELOAD;
          first_d    = 1'b0;
          if (first_q) begin
            csn_d   = 1'b0;
            state_d = SETUP;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SETUP: begin
        if (div_tick) begin
          div_cnt_d = DIV_RELOAD;
          state_d   = SHIFT;
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end

      SHIFT: begin
        if (!div_tick) begin
          div_cnt_d = div_cnt_q - 8'd1;
        end else begin
          div_cnt_d  = DIV_RELOAD;
          sck_d      = ~sck_q;
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (!sck_q) begin
            // Rising edge: capture MISO on the same clock that raises SCK.
            rx_sh_d = {rx_sh_q[6:0], miso_i};
          end else if (edge_cnt_q != 4'd15) begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            mosi_d  = tx_sh_q[6];
          end else begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            if (rem_q != 4'd0) begin
              rem_d   = rem_q - 4'd1;
              state_d = LOAD;
            end else begin
              state_d = HOLD;
            end
          end
        end
      end

      HOLD: begin
        if (div_tick) begin
          csn_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end

      default: begin
        csn_d   = 1'b1;
        sck_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they align with it.
    tx_ready_d = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q    <= IDLE;
      div_cnt_q  <= 8'd0;
      edge_cnt_q <= 4'd0;
      rem_q      <= 4'd0;
      first_q    <= 1'b0;
      sck_q      <= 1'b0;
      csn_q      <= 1'b1;
      mosi_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      rem_q      <= rem_d;
      first_q    <= first_d;
      sck_q      <= sck_d;
      csn_q      <= csn_d;
      mosi_q     <= mosi_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Shift registers are pure data and are always fully loaded before use.
  always_ff @(posedge wb_clk_i) begin
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  assign tx_ready_o = tx_ready_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign sck_o      = sck_q;
  assign csn_o      = csn_q;
  assign mosi_o     = mosi_q;

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 2: SCK half-period in wb_clk_i cycles, legal range 1..255.
REQ-002 SHALL have port wb_clk_i  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port wb_rst_ni  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port start_i  in  1  transaction request, sampled only in IDLE.
REQ-005 SHALL have port len_i  in  4  byte count minus one (0 -> 1 byte, 15 -> 16 bytes), latched with start_i.
REQ-006 SHALL have ports tx_data_i  in  8  next byte to send, and tx_valid_i  in  1  tx_data_i valid.
REQ-007 SHALL have port tx_ready_o  out  1  controller can accept the next tx byte.
REQ-008 SHALL have ports rx_data_o  out  8  last received byte, and rx_valid_o  out  1  one-cycle strobe.
REQ-009 SHALL have ports busy_o  out  1  transaction active, and done_o  out  1  one-cycle end-of-transaction strobe.
REQ-010 SHALL have ports sck_o  out  1, csn_o  out  1 (active-low select), mosi_o  out  1, miso_i  in  1; SPI mode 0 (CPOL=0, CPHA=0), MSB first.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, SETUP, SHIFT, HOLD.
REQ-012 IDLE: start_i=1 SHALL latch len_i into the remaining-byte counter and go to LOAD; start_i is ignored in every other state.
REQ-013 LOAD: tx_ready_o=1; on tx_valid_i&tx_ready_o SHALL load tx_data_i into the shift register, drive mosi_o=tx_data_i[7], and go to SETUP (first byte) or SHIFT (later bytes).
REQ-014 LOAD with tx_valid_i=0 SHALL stall indefinitely, with sck_o=0 and csn_o unchanged (low after the first byte).
REQ-015 SETUP: csn_o=0 and sck_o=0 SHALL hold for DIV cycles, then go to SHIFT.
REQ-016 SHIFT: sck_o SHALL toggle every DIV cycles, giving 8 rising and 8 falling edges, 16*DIV cycles per byte.
REQ-017 miso_i SHALL be sampled into the rx shift register on the wb_clk_i edge that sets sck_o 0->1.
REQ-018 On each falling sck_o edge except the 8th, the tx shift register SHALL shift left and mosi_o SHALL present the next bit.
REQ-019 On the 8th falling edge, rx_data_o SHALL update and rx_valid_o SHALL pulse for exactly 1 cycle.
REQ-020 After the 8th falling edge: if remaining count > 0, decrement it and go to LOAD; if 0, go to HOLD.
REQ-021 HOLD: csn_o=0 and sck_o=0 SHALL hold for DIV cycles, then csn_o goes to 1, done_o pulses for 1 cycle, and the FSM returns to IDLE.
REQ-022 busy_o SHALL be 1 in every state except IDLE.
REQ-023 The divider counter SHALL reload at every state entry; the byte counter SHALL never wrap below 0.
REQ-024 sck_o SHALL be 0 whenever csn_o=1, and csn_o SHALL stay low for the whole multi-byte transaction.
REQ-025 start_i and tx_valid_i high in the same IDLE cycle SHALL take IDLE->LOAD only; the byte is accepted in LOAD on the next cycle.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 wb_rst_ni=0 at a clock edge SHALL force state IDLE, csn_o=1, sck_o=0, mosi_o=0, tx_ready_o=0, rx_valid_o=0, done_o=0, busy_o=0, rx_data_o=8'h00, and clear all counters.
REQ-028 Reset asserted mid-transaction SHALL abort it without a done_o pulse; csn_o=1 on the first cycle after the reset edge.
REQ-029 No output SHALL change between reset edges other than as specified in REQ-027.

Verification
REQ-030 DIV=2, len_i=0, tx 8'hA5, miso_i driven from a mode-0 SPI slave preloaded with 8'h3C -> mosi bits 1,0,1,0,0,1,0,1; rx_data_o=8'h3C; SETUP 2 + SHIFT 32 + HOLD 2 cycles; one done_o pulse.
REQ-031 len_i=2, tx 8'h01,8'h02,8'h03 supplied back-to-back -> csn_o continuously low, 24 sck rising edges, three rx_valid_o pulses, one done_o.
REQ-032 len_i=1, tx_valid_i withheld 50 cycles before the second byte -> sck_o=0 and csn_o=0 throughout the stall, transfer resumes correctly.
REQ-033 start_i pulsed while busy_o=1 -> ignored; transaction length unchanged.
REQ-034 wb_rst_ni=0 during the 4th bit of a byte -> csn_o=1, sck_o=0, busy_o=0 next cycle, no done_o; a fresh len_i=0 transfer then completes normally.
REQ-035 DIV=1, len_i=15, all 16 bytes 8'hFF -> 128 sck periods of 2 cycles each, 16 rx_valid_o pulses.
